// File: rtl/ped_req_cond.sv
// Pedestrian request conditioner: synchronises and debounces the raw push
// button, emits a one-cycle press pulse, and latches a pending request for
// the crosswalk FSM until walk service begins.
module ped_req_cond #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DB_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       walk,
  output logic       req,
  output logic       btn_db,
  output logic       btn_pulse,
  output logic [3:0] req_cnt,
  output logic [1:0] st
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PEND  = 2'b01,
    SERVE = 2'b10
  } state_t;

  logic            r_q1;
  logic            r_sync;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_btn_db;
  logic            r_btn_pulse;
  logic [3:0]      r_req_cnt;
  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_cnt_clr;
  logic            w_cnt_inc;
  logic            w_db_flip;

  // A debounced change is accepted once the disagreement has lasted DB_CYCLES edges.
  assign w_db_flip = (r_sync != r_btn_db) && (r_db_cnt == DB_LAST);

  // Two-flop synchroniser for the asynchronous button; nothing sits between the flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q1   <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_q1   <= btn_raw;
      r_sync <= r_q1;
    end
  end

  // Debounce counter and debounced level; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_db_cnt <= '0;
      r_btn_db <= 1'b0;
    end else if (r_sync == r_btn_db) begin
      r_db_cnt <= '0;
    end else if (w_db_flip) begin
      r_db_cnt <= '0;
      r_btn_db <= r_sync;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // Press pulse fires with the rising debounced edge only, and lasts one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_btn_pulse <= 1'b0;
    end else begin
      r_btn_pulse <= w_db_flip && r_sync;
    end
  end

  // Request FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and press-count control; walk wins over a simultaneous press.
  always_comb begin
    w_state_nxt = IDLE;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (walk) begin
          w_state_nxt = SERVE;
          w_cnt_clr   = 1'b1;
        end else if (r_btn_pulse) begin
          w_state_nxt = PEND;
          w_cnt_inc   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PEND: begin
        if (walk) begin
          w_state_nxt = SERVE;
          w_cnt_clr   = 1'b1;
        end else begin
          w_state_nxt = PEND;
          w_cnt_inc   = r_btn_pulse;
        end
      end
      SERVE: begin
        w_state_nxt = walk ? SERVE : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Saturating count of presses accumulated while a request is pending.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req_cnt <= 4'd0;
    end else if (w_cnt_clr) begin
      r_req_cnt <= 4'd0;
    end else if (w_cnt_inc && (r_req_cnt != 4'hF)) begin
      r_req_cnt <= r_req_cnt + 4'd1;
    end
  end

  assign req       = (r_state == PEND);
  assign btn_db    = r_btn_db;
  assign btn_pulse = r_btn_pulse;
  assign req_cnt   = r_req_cnt;
  assign st        = r_state;

endmodule

// File: tb/tb_ped_req_cond.sv
// Directed bench for ped_req_cond with DB_CYCLES=4.
module tb_ped_req_cond;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic       walk;
  logic       req;
  logic       btn_db;
  logic       btn_pulse;
  logic [3:0] req_cnt;
  logic [1:0] st;

  int n_checks = 0;
  int n_fail   = 0;

  ped_req_cond #(.DB_CYCLES(4), .DB_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .walk      (walk),
    .req       (req),
    .btn_db    (btn_db),
    .btn_pulse (btn_pulse),
    .req_cnt   (req_cnt),
    .st        (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full debounced press and release: pulse at edge 6, button back low after 12 edges.
  task automatic press();
    btn_raw = 1'b1;
    repeat (6) step();
    btn_raw = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    reset   = 1'b0;
    btn_raw = 1'b0;
    walk    = 1'b0;
    step();
    step();
    check("rst_req",   32'(req),       32'd0);
    check("rst_db",    32'(btn_db),    32'd0);
    check("rst_pulse", 32'(btn_pulse), 32'd0);
    check("rst_cnt",   32'(req_cnt),   32'd0);
    check("rst_st",    32'(st),        32'd0);
    reset = 1'b1;
    step();

    // Clean press: debounced at edge 6, request at edge 7.
    btn_raw = 1'b1;
    repeat (5) step();
    check("clean_db_e5",    32'(btn_db),    32'd0);
    check("clean_pulse_e5", 32'(btn_pulse), 32'd0);
    step();
    check("clean_db_e6",    32'(btn_db),    32'd1);
    check("clean_pulse_e6", 32'(btn_pulse), 32'd1);
    check("clean_req_e6",   32'(req),       32'd0);
    step();
    check("clean_pulse_e7", 32'(btn_pulse), 32'd0);
    check("clean_req_e7",   32'(req),       32'd1);
    check("clean_st_e7",    32'(st),        32'd1);
    check("clean_cnt_e7",   32'(req_cnt),   32'd1);

    // Release: btn_db falls at edge 6 with no pulse.
    btn_raw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("rel_pulse", 32'(btn_pulse), 32'd0);
    end
    check("rel_db", 32'(btn_db), 32'd0);
    check("rel_st", 32'(st),     32'd1);

    // Two more presses while pending.
    press();
    press();
    check("pend_cnt3", 32'(req_cnt), 32'd3);
    check("pend_st",   32'(st),      32'd1);

    // Service: walk clears the request and count; presses ignored during walk.
    walk = 1'b1;
    step();
    check("srv_st",  32'(st),      32'd2);
    check("srv_req", 32'(req),     32'd0);
    check("srv_cnt", 32'(req_cnt), 32'd0);
    press();
    check("srv_press_st",  32'(st),      32'd2);
    check("srv_press_cnt", 32'(req_cnt), 32'd0);
    check("srv_press_req", 32'(req),     32'd0);
    walk = 1'b0;
    step();
    check("srv_end_st", 32'(st), 32'd0);

    // Glitch: three raw cycles high never reach the debounced level.
    btn_raw = 1'b1;
    repeat (3) step();
    btn_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("gl_pulse", 32'(btn_pulse), 32'd0);
      check("gl_db",    32'(btn_db),    32'd0);
    end
    check("gl_dbcnt", 32'(dut.r_db_cnt), 32'd0);
    check("gl_req",   32'(req),          32'd0);
    check("gl_st",    32'(st),           32'd0);

    // Priority: pulse and walk on the same edge in IDLE go straight to SERVE.
    btn_raw = 1'b1;
    repeat (6) step();
    check("pri_pulse", 32'(btn_pulse), 32'd1);
    check("pri_req6",  32'(req),       32'd0);
    walk = 1'b1;
    step();
    check("pri_st",  32'(st),      32'd2);
    check("pri_req", 32'(req),     32'd0);
    check("pri_cnt", 32'(req_cnt), 32'd0);
    btn_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("pri_noreq", 32'(req), 32'd0);
    end
    walk = 1'b0;
    step();
    check("pri_idle", 32'(st), 32'd0);

    // Saturation: twenty presses hold the count at 15.
    for (int i = 1; i <= 20; i++) begin
      press();
      if (i == 14) check("sat_cnt14", 32'(req_cnt), 32'd14);
      if (i == 15) check("sat_cnt15", 32'(req_cnt), 32'd15);
    end
    check("sat_cnt20", 32'(req_cnt), 32'd15);
    check("sat_st",    32'(st),      32'd1);

    // Reset mid-debounce while pending, button held through release.
    btn_raw = 1'b1;
    repeat (4) step();
    check("mid_dbcnt2", 32'(dut.r_db_cnt), 32'd2);
    reset = 1'b0;
    step();
    check("mr_req",   32'(req),          32'd0);
    check("mr_db",    32'(btn_db),       32'd0);
    check("mr_pulse", 32'(btn_pulse),    32'd0);
    check("mr_cnt",   32'(req_cnt),      32'd0);
    check("mr_st",    32'(st),           32'd0);
    check("mr_dbcnt", 32'(dut.r_db_cnt), 32'd0);
    reset = 1'b1;
    repeat (5) step();
    check("mr_pulse_e5", 32'(btn_pulse), 32'd0);
    step();
    check("mr_pulse_e6", 32'(btn_pulse), 32'd1);
    check("mr_db_e6",    32'(btn_db),    32'd1);
    step();
    check("mr_req_e7", 32'(req),     32'd1);
    check("mr_st_e7",  32'(st),      32'd1);
    check("mr_cnt_e7", 32'(req_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
